// File: rtl/pu_or1k_pkg.sv
// Shared OR1K processing-unit definitions: SPR address layout, well-known SPR
// addresses and the SPR bus initiator state encoding.
package pu_or1k_pkg;

  localparam int SPR_GROUP_W  = 5;
  localparam int SPR_OFFSET_W = 11;
  localparam int SPR_ADDR_W   = SPR_GROUP_W + SPR_OFFSET_W;

  localparam logic [SPR_ADDR_W-1:0] SPR_PICMR = 16'h4800;
  localparam logic [SPR_ADDR_W-1:0] SPR_PICSR = 16'h4802;

  typedef enum logic [1:0] {
    SPR_IDLE   = 2'd0,
    SPR_ACCESS = 2'd1,
    SPR_RESP   = 2'd2
  } spr_master_state_t;

  function automatic logic [SPR_GROUP_W-1:0] spr_group(input logic [SPR_ADDR_W-1:0] addr);
    return addr[SPR_ADDR_W-1:SPR_OFFSET_W];
  endfunction

endpackage

// File: rtl/pu_or1k_spr_master_if.sv
// SPR bus between the pipeline's SPR initiator and the SPR responders
// (PIC, timer, ...). The responder may return ack combinationally from access.
interface pu_or1k_spr_master_if;
  import pu_or1k_pkg::*;

  logic                  spr_access_o;
  logic                  spr_we_o;
  logic [SPR_ADDR_W-1:0] spr_addr_o;
  logic [31:0]           spr_dat_o;
  logic                  spr_bus_ack_i;
  logic [31:0]           spr_dat_i;

  modport master (
    output spr_access_o, spr_we_o, spr_addr_o, spr_dat_o,
    input  spr_bus_ack_i, spr_dat_i
  );

  modport slave (
    input  spr_access_o, spr_we_o, spr_addr_o, spr_dat_o,
    output spr_bus_ack_i, spr_dat_i
  );

endinterface

// File: rtl/pu_or1k_spr_master.sv
// SPR bus initiator: runs one mtspr/mfspr per request, waits for the responder
// ack (or times out) and reports completion with a single-cycle done pulse.
module pu_or1k_spr_master
  import pu_or1k_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [SPR_ADDR_W-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  abort_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  pu_or1k_spr_master_if.master  spr
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  spr_master_state_t     state_q, state_d;
  logic                  we_q, we_d;
  logic [SPR_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // NOTE: every signal assigned here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      SPR_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = we_i ? wdata_i : '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = SPR_ACCESS;
        end
      end
      SPR_ACCESS: begin
        // Ack outranks both abort and timeout so a completed access is never lost.
        if (spr.spr_bus_ack_i) begin
          rdata_d = we_q ? '0 : spr.spr_dat_i;
          err_d   = 1'b0;
          state_d = SPR_RESP;
        end else if (abort_i) begin
          state_d = SPR_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = SPR_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SPR_RESP: state_d = SPR_IDLE;
      default:  state_d = SPR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SPR_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus strobes decode straight from the state register, so reset drops them at once.
  assign ready_o          = (state_q == SPR_IDLE);
  assign done_o           = (state_q == SPR_RESP);
  assign err_o            = err_q;
  assign rdata_o          = rdata_q;
  assign spr.spr_access_o = (state_q == SPR_ACCESS);
  assign spr.spr_we_o     = (state_q == SPR_ACCESS) && we_q;
  assign spr.spr_addr_o   = addr_q;
  assign spr.spr_dat_o    = wdata_q;

endmodule

// File: tb/tb_pu_or1k_spr_master.sv
// Bench for pu_or1k_spr_master: a PIC-like responder with programmable ack
// delay, directed vectors, hand-written corner sequences and random traffic.
module tb_pu_or1k_spr_master;
  import pu_or1k_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, abort_i;
  logic [15:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o, done_o, err_o;
  logic [31:0] rdata_o;

  pu_or1k_spr_master_if spr ();

  pu_or1k_spr_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .abort_i (abort_i),
    .ready_o (ready_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .rdata_o (rdata_o),
    .spr     (spr)
  );

  always #5 clk = ~clk;

  // Responder: PICMR read/write, PICSR = level irq masked by PICMR, anything else
  // returns {addr, ~addr}. Ack comes on access cycle index ack_delay (-1 = never).
  int          ack_delay;
  logic        stray_ack;
  logic [31:0] irq;
  logic [31:0] picmr_r;
  int          acc_cnt;

  function automatic logic [31:0] resp_data(input logic [15:0] a, input logic [31:0] mr,
                                            input logic [31:0] lvl);
    if (a == SPR_PICMR) return mr;
    if (a == SPR_PICSR) return lvl & mr;
    return {a, ~a};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                    acc_cnt <= 0;
    else if (!spr.spr_access_o) acc_cnt <= 0;
    else                        acc_cnt <= acc_cnt + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) picmr_r <= '0;
    else if (spr.spr_access_o && spr.spr_we_o && spr.spr_bus_ack_i && spr.spr_addr_o == SPR_PICMR)
      picmr_r <= spr.spr_dat_o;
  end

  assign spr.spr_bus_ack_i = stray_ack ||
                             (spr.spr_access_o && ack_delay >= 0 && acc_cnt == ack_delay);
  assign spr.spr_dat_i     = resp_data(spr.spr_addr_o, picmr_r, irq);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          d;
    int          a;
    logic [31:0] irq;
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;
  } vec_t;

  // Reference model: whichever of ack, abort and timeout comes first in access
  // cycle order decides the outcome; ties go ack > abort > timeout.
  logic [31:0] model_picmr;

  task automatic predict(inout vec_t v);
    int ack_at, ab_at, to_at;
    ack_at = (v.d >= 0) ? v.d : 1000;
    ab_at  = (v.a >= 0) ? v.a : 1000;
    to_at  = (T > 0) ? T - 1 : 1000;
    v.exp_rdata = '0;
    v.exp_err   = 1'b0;
    if (ack_at <= ab_at && ack_at <= to_at) begin
      v.exp_done  = 1'b1;
      v.exp_rdata = v.we ? 32'h0 : resp_data(v.addr, model_picmr, v.irq);
      v.exp_acc   = ack_at + 1;
      if (v.we && v.addr == SPR_PICMR) model_picmr = v.wdata;
    end else if (ab_at <= to_at) begin
      v.exp_done = 1'b0;
      v.exp_acc  = ab_at + 1;
    end else begin
      v.exp_done = 1'b1;
      v.exp_err  = 1'b1;
      v.exp_acc  = T;
    end
  endtask

  // Drive one request, watch the bus and the response, and compare.
  task automatic run_vec(input vec_t v, input string tag);
    int   acc, done_k;
    logic done_seen, fin, bus_ok, got_err, post_ready, post_done;
    logic [31:0] got_rdata;
    @(negedge clk);
    irq       = v.irq;
    ack_delay = v.d;
    req_i     = 1'b1;
    we_i      = v.we;
    addr_i    = v.addr;
    wdata_i   = v.wdata;
    abort_i   = 1'b0;
    check({tag, " ready_before"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    req_i = 1'b0;
    acc = 0; done_k = -1; done_seen = 0; fin = 0; bus_ok = 1;
    got_err = 0; got_rdata = '0; post_ready = 0; post_done = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (spr.spr_access_o) begin
        if (spr.spr_addr_o !== v.addr || spr.spr_we_o !== v.we ||
            spr.spr_dat_o !== (v.we ? v.wdata : 32'h0) || done_o !== 1'b0)
          bus_ok = 0;
        abort_i = (acc == v.a);
        acc++;
      end else begin
        abort_i = 1'b0;
        if (done_o) begin
          done_seen = 1; done_k = k; got_err = err_o; got_rdata = rdata_o; fin = 1;
        end else if (ready_o) begin
          fin = 1; post_ready = ready_o; post_done = done_o;
        end
      end
      if (!fin) @(negedge clk);
    end
    abort_i = 1'b0;
    check({tag, " finished_in_budget"}, 32'(fin), 32'd1);
    if (done_seen) begin
      @(negedge clk);
      post_ready = ready_o; post_done = done_o;
    end
    check({tag, " done"}, 32'(done_seen), 32'(v.exp_done));
    check({tag, " access_cycles"}, 32'(acc), 32'(v.exp_acc));
    check({tag, " bus_stable"}, 32'(bus_ok), 32'd1);
    check({tag, " ready_after"}, 32'(post_ready), 32'd1);
    check({tag, " done_one_cycle"}, 32'(post_done), 32'd0);
    if (v.exp_done) begin
      check({tag, " err"}, 32'(got_err), 32'(v.exp_err));
      check({tag, " rdata"}, got_rdata, v.exp_rdata);
      check({tag, " done_latency"}, 32'(done_k), 32'(acc));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[10];

  initial begin
    vec_t v;
    int   accepts, dones, last_done;
    logic gaps_ok, overlap;

    rst = 1'b1; req_i = 0; we_i = 0; abort_i = 0; addr_i = '0; wdata_i = '0;
    ack_delay = -1; stray_ack = 0; irq = '0; model_picmr = '0;

    tbl[0] = '{1'b1, 16'h4800, 32'h0000_00F0,  0, -1, 32'h0,  1'b1, 1'b0, 32'h0,          1};
    tbl[1] = '{1'b0, 16'h4800, 32'h0,          0, -1, 32'h0,  1'b1, 1'b0, 32'h0000_00F0,  1};
    tbl[2] = '{1'b0, 16'h4802, 32'h0,          0, -1, 32'h30, 1'b1, 1'b0, 32'h0000_0030,  1};
    tbl[3] = '{1'b0, 16'h5000, 32'h0,         -1, -1, 32'h0,  1'b1, 1'b1, 32'h0,          16};
    tbl[4] = '{1'b0, 16'h5000, 32'h0,          5,  3, 32'h0,  1'b0, 1'b0, 32'h0,          4};
    tbl[5] = '{1'b0, 16'h5000, 32'h0,          2,  2, 32'h0,  1'b1, 1'b0, 32'h5000_AFFF,  3};
    tbl[6] = '{1'b0, 16'h1234, 32'h0,         15, -1, 32'h0,  1'b1, 1'b0, 32'h1234_EDCB,  16};
    tbl[7] = '{1'b1, 16'h1234, 32'hDEAD_BEEF, 16, -1, 32'h0,  1'b1, 1'b1, 32'h0,          16};
    tbl[8] = '{1'b1, 16'h4800, 32'h0000_0055, -1, 15, 32'h0,  1'b0, 1'b0, 32'h0,          16};
    tbl[9] = '{1'b1, 16'h2000, 32'hCAFE_0001,  3, -1, 32'h0,  1'b1, 1'b0, 32'h0,          4};

    repeat (2) @(negedge clk);
    check("rst ready", 32'(ready_o), 32'd1);
    check("rst done", 32'(done_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst rdata", rdata_o, 32'h0);
    check("rst access", 32'(spr.spr_access_o), 32'd0);
    check("rst we", 32'(spr.spr_we_o), 32'd0);
    check("rst addr", 32'(spr.spr_addr_o), 32'h0);
    check("rst dat", spr.spr_dat_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    check("pic picmr", picmr_r, 32'h0000_00F0);
    model_picmr = 32'h0000_00F0;

    // Ack while idle must not start or complete anything.
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_ack ready", 32'(ready_o), 32'd1);
    check("stray_ack done", 32'(done_o), 32'd0);
    stray_ack = 1'b0;

    // Back-to-back reads with req held: three done pulses exactly 3 cycles apart.
    ack_delay = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = SPR_PICMR;
    accepts = 0; dones = 0; last_done = -1; gaps_ok = 1; overlap = 0;
    for (int k = 0; k < 20; k++) begin
      if (accepts == 3 && !ready_o) req_i = 1'b0;
      if (done_o && spr.spr_access_o) overlap = 1;
      if (done_o) begin
        dones++;
        if (last_done >= 0 && k - last_done != 3) gaps_ok = 0;
        last_done = k;
      end
      if (ready_o && req_i) accepts++;
      @(negedge clk);
    end
    req_i = 1'b0;
    check("b2b dones", 32'(dones), 32'd3);
    check("b2b spacing", 32'(gaps_ok), 32'd1);
    check("b2b no_access_in_resp", 32'(overlap), 32'd0);
    check("b2b rdata", rdata_o, 32'h0000_00F0);

    // Reset in the middle of an access.
    ack_delay = -1;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 16'h5000; wdata_i = 32'h1111_2222;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    check("midrst access_before", 32'(spr.spr_access_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst access_async", 32'(spr.spr_access_o), 32'd0);
    check("midrst ready_async", 32'(ready_o), 32'd1);
    check("midrst done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready_after", 32'(ready_o), 32'd1);
    check("midrst done_after", 32'(done_o), 32'd0);
    model_picmr = '0;
    v = '{1'b1, 16'h4800, 32'h0000_00A5, 0, -1, 32'h0, 1'b1, 1'b0, 32'h0, 1};
    run_vec(v, "post_rst_write");
    check("post_rst picmr", picmr_r, 32'h0000_00A5);
    model_picmr = 32'h0000_00A5;

    // Random traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel     = int'($urandom_range(0, 2));
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = (sel == 0) ? SPR_PICMR : (sel == 1) ? SPR_PICSR : 16'($urandom);
      v.wdata = $urandom;
      v.irq   = $urandom;
      v.d     = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 18));
      v.a     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1;
      predict(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end
    check("rnd picmr", picmr_r, model_picmr);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
